booth_pp_gen: RTL and testbench
===============================

# booth_pp_gen

Registered radix-4 Booth partial-product generator that feeds the Dadda reduction tree of the `booth_mul` datapath. It accepts an 11-bit signed multiplicand/multiplier pair through a valid/ready handshake. It recodes the multiplier into six Booth digits and emits six 13-bit partial-product rows plus six negation-correction bits. Output is in the row format the tree consumes: a two-stage pipeline with full backpressure.

## Interface
- `A_W`, default 11: multiplicand/multiplier width, two's complement; fixed at 11 for the current tree.
- `N_PP`, default 6: number of Booth digits, equal to ceil((A_W+1)/2).
- `PP_W`, default 13: row width, equal to A_W+2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept an operand pair this cycle.
- `a`  in  11: multiplicand, signed.
- `b`  in  11: multiplier, signed.
- `out_valid`  out  1: rows valid.
- `out_ready`  in  1: downstream accepts the rows.
- `ops`  out  [5:0][12:0]: partial-product rows to the tree.
- `neg`  out  6: per-row +1 correction, weight 2^(2i).

## Operation
- **Recoding.** Form b_ext = {b[10], b, 1'b0} (13 bits, with b[-1]=0). Digit i uses the triplet (b_ext[2i+2], b_ext[2i+1], b_ext[2i]):
  - 000 and 111 → 0
  - 001 and 010 → +1
  - 011 → +2
  - 100 → −2
  - 101 and 110 → −1
- **Magnitude.** Let a_ext be `a` sign-extended to 12 bits. The magnitude is m = 0, a_ext, or a_ext<<1 (12 bits; bit 11 of a_ext is dropped on the shift).
- **Negative digits.** pp_i = ~m and neg[i] = 1. Otherwise pp_i = m and neg[i] = 0. A zero digit gives pp_i = 0 and neg[i] = 0, never ~0.
- **Row format.** ops[i] = {~pp_i[11], pp_i[11:0]}, so the inverted sign occupies bit 12. Rows are unshifted; the tree applies the 2i alignment and the sign-extension constants.
- **Exactness.** Sum over i of (pp_i + neg[i]) * 4^i equals a*b exactly in two's complement.
- **Stage 1.** Registers `a` and the six 3-bit digit codes, plus the valid bit s1_v.
- **Stage 2.** Registers `ops`, `neg` and out_valid (s2_v).
- **Handshake.**
  - A transfer occurs on any edge where valid && ready.
  - s2 can load when !s2_v || out_ready.
  - s1 can load when !s1_v || (s2 can load).
  - in_ready = !s1_v || s2_can_load, which is combinational from out_ready.
  - s1 advances into s2 on (s1_v && s2 can load).
- **Output stability.** While out_valid && !out_ready, `ops` and `neg` stay stable.
- **Ordering.** No reordering and no drops. Simultaneous accept-in, advance and accept-out in one cycle sustain a throughput of 1 operand pair per cycle.

## Timing
- Latency is 2 cycles: a transfer accepted at edge k gives out_valid high after edge k+1 (visible in cycle k+1→k+2) when out_ready is held high.
- Reset values:
  - s1_v = 0, out_valid = 0, ops = 0, neg = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Reset mid-operation discards both stages and drops any in-flight pairs. No output transfer occurs in a reset cycle.
- Full condition: with both stages valid and out_ready=0, in_ready=0. When out_ready rises, in_ready rises in the same cycle.
- Empty condition: with both stages invalid, out_valid=0 regardless of inputs.
- Data registers need no reset functionally; they are reset to 0 anyway for deterministic benches.

## Structure
- **Package `booth_pkg`:**
  - constants A_W, N_PP, PP_W.
  - typedef `booth_digit_t`: 3-bit enum ZERO, POS1, POS2, NEG1, NEG2.
  - typedef `pp_row_t` = logic [PP_W-1:0].
- **Sub-module `booth_encoder`:** combinational, mapping triplet → booth_digit_t. Instantiated N_PP times in stage 1.
- **Stage-2 row logic:** the selector and inverter that forms each row is a function in `booth_pkg`, not a module.

## Test plan
- **+1 and −1 digits.** a=5, b=3 → digits d0=−1, d1=+1, d2..5=0. Expect:
  - ops[0]=13'h0FFA, ops[1]=13'h1005, ops[2..5]=13'h1000.
  - neg=6'b000001.
  - out_valid two edges after acceptance.
- **−2 digit.** a=3, b=2 → d0=−2, d1=+1. Expect ops[0]=13'h0FF9, neg[0]=1, ops[1]=13'h1003.
- **Corner case.** a=−1024, b=−1024 → only d5=−1. Expect ops[5]=13'h13FF, neg=6'b100000, all other rows 13'h1000. Reference-model reconstruction of the row sum equals 1048576.
- **Backpressure.**
  - Stream 4 pairs with out_ready=0.
  - Expect 2 accepted, then in_ready=0, with `ops` stable.
  - Release out_ready: expect in-order delivery, with in_ready high in the same cycle.
- **Reset mid-stream.** Assert rst with both stages valid. Expect out_valid=0 and ops=0 the next cycle, and none of the pre-reset pairs ever emitted.
- **Random regression.** 10k random pairs with random valid/ready. The scoreboard reconstructs Σ(row value + neg)·4^i and checks it equals a*b.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared constants, Booth digit type and the row-forming function for booth_pp_gen.
package booth_pkg;

  localparam int unsigned A_W  = 11;
  localparam int unsigned N_PP = (A_W + 2) / 2;
  localparam int unsigned PP_W = A_W + 2;
  localparam int unsigned M_W  = A_W + 1;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  typedef logic [PP_W-1:0] pp_row_t;

  typedef struct packed {
    logic    neg;
    pp_row_t row;
  } pp_out_t;

  // Select 0/a/2a, invert for negative digits, and prepend the inverted sign bit.
  function automatic pp_out_t booth_row(input logic [A_W-1:0] a, input booth_digit_t d);
    logic [M_W-1:0] m;
    logic [M_W-1:0] pp;
    logic           is_neg;
    pp_out_t        r;
    case (d)
      POS1, NEG1: m = {a[A_W-1], a};
      POS2, NEG2: m = {a, 1'b0};
      default:    m = '0;
    endcase
    is_neg = (d == NEG1) || (d == NEG2);
    pp     = is_neg ? ~m : m;
    r.neg  = is_neg;
    r.row  = {~pp[M_W-1], pp};
    return r;
  endfunction

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth recoder: one multiplier triplet to one signed digit.
module booth_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   trip,
  output booth_digit_t digit_c
);

  always_comb begin
    digit_c = ZERO;
    case (trip)
      3'b001, 3'b010: digit_c = POS1;
      3'b011:         digit_c = POS2;
      3'b100:         digit_c = NEG2;
      3'b101, 3'b110: digit_c = NEG1;
      default:        digit_c = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Two-stage radix-4 Booth partial-product generator with valid/ready backpressure.
// Stage 1 holds the multiplicand and recoded digits; stage 2 holds the formed rows.
module booth_pp_gen
  import booth_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [A_W-1:0]                 a,
  input  logic [A_W-1:0]                 b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_PP-1:0][PP_W-1:0]      ops,
  output logic [N_PP-1:0]                neg
);

  logic [PP_W-1:0]           b_ext;
  booth_digit_t              dig_c [N_PP];
  pp_out_t                   row_c [N_PP];
  logic                      s1_load_c;
  logic                      s2_load_c;

  logic                      s1_v_q,  s1_v_d;
  logic [A_W-1:0]            a_q,     a_d;
  booth_digit_t              dig_q [N_PP];
  booth_digit_t              dig_d [N_PP];
  logic                      s2_v_q,  s2_v_d;
  logic [N_PP-1:0][PP_W-1:0] ops_q,   ops_d;
  logic [N_PP-1:0]           neg_q,   neg_d;

  assign b_ext = {b[A_W-1], b, 1'b0};

  for (genvar g = 0; g < N_PP; g++) begin : g_enc
    booth_encoder u_enc (
      .trip    (b_ext[2*g +: 3]),
      .digit_c (dig_c[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < N_PP; i++) begin
      row_c[i] = booth_row(a_q, dig_q[i]);
    end
  end

  // Pipeline control: each stage loads when empty or when its successor drains.
  always_comb begin
    s2_load_c = !s2_v_q || out_ready;
    s1_load_c = !s1_v_q || s2_load_c;
    s1_v_d    = s1_v_q;
    a_d       = a_q;
    dig_d     = dig_q;
    s2_v_d    = s2_v_q;
    ops_d     = ops_q;
    neg_d     = neg_q;
    if (s1_load_c) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        a_d   = a;
        dig_d = dig_c;
      end
    end
    if (s2_load_c) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        for (int unsigned i = 0; i < N_PP; i++) begin
          ops_d[i] = row_c[i].row;
          neg_d[i] = row_c[i].neg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      a_q    <= '0;
      for (int unsigned i = 0; i < N_PP; i++) begin
        dig_q[i] <= ZERO;
      end
      s2_v_q <= 1'b0;
      ops_q  <= '0;
      neg_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      a_q    <= a_d;
      dig_q  <= dig_d;
      s2_v_q <= s2_v_d;
      ops_q  <= ops_d;
      neg_q  <= neg_d;
    end
  end

  assign in_ready  = s1_load_c;
  assign out_valid = s2_v_q;
  assign ops       = ops_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Scoreboard bench for booth_pp_gen: directed Booth vectors, backpressure, reset, random stream.
module tb_booth_pp_gen;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [10:0]       a;
  logic [10:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic [5:0][12:0]  ops;
  logic [5:0]        neg;

  booth_pp_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ops       (ops),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [77:0] ops;
    logic [5:0]  neg;
    longint      prod;
    bit          chk_rows;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rand_ready = 1'b0;

  localparam logic [12:0] Z = 13'h1000;
  logic [10:0] va [6];
  logic [10:0] vb [6];
  logic [77:0] vo [6];
  logic [5:0]  vn [6];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [10:0] x, input logic [10:0] y,
                              input logic [77:0] eo, input logic [5:0] en, input bit cr);
    exp_t e;
    e.ops      = eo;
    e.neg      = en;
    e.prod     = longint'($signed(x)) * longint'($signed(y));
    e.chk_rows = cr;
    return e;
  endfunction

  // Sum of (signed 12-bit row value + neg) * 4^i
  function automatic longint recon(input logic [77:0] o, input logic [5:0] n);
    longint s = 0;
    for (int i = 0; i < 6; i++) begin
      s += (longint'($signed(o[13*i +: 12])) + longint'(n[i])) * (longint'(1) << (2*i));
    end
    return s;
  endfunction

  task automatic drive_ready();
    if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send(input logic [10:0] x, input logic [10:0] y,
                      input logic [77:0] eo, input logic [5:0] en, input bit cr);
    int guard = 0;
    @(negedge clk);
    drive_ready();
    a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck low for a=%0h b=%0h", x, y);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      drive_ready();
      #1;
    end
    sb_q.push_back(mk(x, y, eo, en, cr));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_ready();
      in_valid = 1'b0;
    end
  endtask

  // Monitor: compare every output transfer against the head of the scoreboard.
  initial begin : monitor
    exp_t        e;
    logic [77:0] got;
    bit          fmt_ok;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        got = ops;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: ops=%0h neg=%0h with empty scoreboard", got, neg);
        end else begin
          e = sb_q.pop_front();
          check("row_sum", 128'(recon(got, neg)), 128'(e.prod));
          fmt_ok = 1'b1;
          for (int i = 0; i < 6; i++) begin
            if (got[13*i + 12] !== ~got[13*i + 11]) fmt_ok = 1'b0;
          end
          check("row_sign_format", fmt_ok, 1'b1);
          if (e.chk_rows) begin
            check("rows", got, e.ops);
            check("neg", neg, e.neg);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [77:0] snap;
    int          g;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    va[0] = 11'd5;    vb[0] = 11'd3;    vo[0] = {Z, Z, Z, Z, 13'h1005, 13'h0FFA}; vn[0] = 6'b000001;
    va[1] = 11'd3;    vb[1] = 11'd2;    vo[1] = {Z, Z, Z, Z, 13'h1003, 13'h0FF9}; vn[1] = 6'b000001;
    va[2] = 11'h400;  vb[2] = 11'h400;  vo[2] = {13'h13FF, Z, Z, Z, Z, Z};        vn[2] = 6'b100000;
    va[3] = 11'd0;    vb[3] = 11'd0;    vo[3] = {Z, Z, Z, Z, Z, Z};               vn[3] = 6'b000000;
    va[4] = 11'd1023; vb[4] = 11'd1;    vo[4] = {Z, Z, Z, Z, Z, 13'h13FF};        vn[4] = 6'b000000;
    va[5] = 11'h7FF;  vb[5] = 11'h7FF;  vo[5] = {Z, Z, Z, Z, Z, Z};               vn[5] = 6'b000001;

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_ops", ops, 78'h0);
    check("reset_neg", neg, 6'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_in_ready", in_ready, 1'b1);

    // Latency: one pair into an empty pipe.
    out_ready = 1'b1;
    send(va[0], vb[0], vo[0], vn[0], 1'b1);
    @(negedge clk); in_valid = 1'b0; #1;
    check("latency_stage1_only", out_valid, 1'b0);
    @(negedge clk); #1;
    check("latency_out_valid", out_valid, 1'b1);

    for (int k = 1; k < 6; k++) send(va[k], vb[k], vo[k], vn[k], 1'b1);
    idle(4);

    // Backpressure: only two pairs fit with out_ready low.
    out_ready = 1'b0;
    snap = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = va[k]; b = vb[k]; in_valid = 1'b1;
      #1;
      check($sformatf("bp_in_ready_%0d", k), in_ready, (k < 2));
      if (in_ready) sb_q.push_back(mk(va[k], vb[k], vo[k], vn[k], 1'b1));
      if (k == 2) snap = ops;
      if (k == 3) begin
        check("bp_ops_stable", ops, snap);
        check("bp_out_valid_held", out_valid, 1'b1);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; a = va[2]; b = vb[2]; in_valid = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    if (in_ready) sb_q.push_back(mk(va[2], vb[2], vo[2], vn[2], 1'b1));
    send(va[3], vb[3], vo[3], vn[3], 1'b1);
    idle(6);
    check("bp_drained", sb_q.size(), 0);

    // Reset with both stages full: in-flight pairs must vanish.
    out_ready = 1'b0;
    send(va[4], vb[4], vo[4], vn[4], 1'b1);
    send(va[5], vb[5], vo[5], vn[5], 1'b1);
    @(negedge clk); in_valid = 1'b0; #1;
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_ops", ops, 78'h0);
    check("midrst_neg", neg, 6'h0);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    check("midrst_in_ready", in_ready, 1'b1);
    idle(5);

    // Random stream with random gaps and random downstream stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(11'($urandom), 11'($urandom), '0, '0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0; rand_ready = 1'b0; out_ready = 1'b1;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    idle(3);
    check("final_scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
